// File: rtl/mul_exec_if.sv
// mul_exec_if: the issue-side and writeback-side handshakes of the multiply execute slot.
//   in_valid/in_ready            : issue handshake
//   in_a, in_b, in_is_mul, in_tag: operation payload (operands, op kind, destination tag)
//   out_valid/out_ready          : writeback handshake
//   out_result, out_tag          : product and its destination tag
// Modport master is the issue/writeback side. Modport slave is the execute slot.
interface mul_exec_if #(
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_is_mul;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_is_mul, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_is_mul, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/mul_exec_stage.sv
// mul_exec_stage: two-stage pipelined 16x16 unsigned multiply execute slot.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   flush : synchronous kill of both stages; it blocks accepts in the same cycle
//   busy  : high while either stage holds an operation
//   bus   : issue/writeback handshakes (mul_exec_if.slave)
// Stage S1 registers the operands. The combinational multiplier is fed from S1, and the output
// register holds the product until writeback takes it.
module mul_exec_stage #(
    parameter int unsigned TAG_W = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    output logic      busy,
    mul_exec_if.slave bus
);

    logic             s1_valid;
    logic [15:0]      s1_a;
    logic [15:0]      s1_b;
    logic             s1_is_mul;
    logic [TAG_W-1:0] s1_tag;

    logic             out_valid_q;
    logic [31:0]      out_result_q;
    logic [TAG_W-1:0] out_tag_q;

    logic             s2_load;
    logic             in_ready;
    logic             accept;
    logic [31:0]      prod;

    // S1 advances whenever the output register is empty or is being drained this cycle.
    always_comb begin
        prod = 32'd0;
        if (s1_is_mul) begin
            prod = {16'b0, s1_a} * {16'b0, s1_b};
        end
        s2_load  = s1_valid & (~out_valid_q | bus.out_ready);
        in_ready = ~flush & (~s1_valid | s2_load);
        accept   = bus.in_valid & in_ready;
    end

    // Only the low operand halves take part in the multiply, so only those bits are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_is_mul <= 1'b0;
            s1_tag    <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (accept) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (accept) begin
                s1_a      <= bus.in_a[15:0];
                s1_b      <= bus.in_b[15:0];
                s1_is_mul <= bus.in_is_mul;
                s1_tag    <= bus.in_tag;
            end
        end
    end

    // A flush leaves result and tag stale. Only out_valid is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (s2_load) begin
            out_valid_q  <= 1'b1;
            out_result_q <= prod;
            out_tag_q    <= s1_tag;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;
    assign busy           = s1_valid | out_valid_q;

endmodule

// File: tb/tb_mul_exec_stage.sv
// tb_mul_exec_stage: self-checking bench for mul_exec_stage.
// The reference model is an in-order queue of expected (product, tag) pairs.
//   - An entry is pushed for every accepted operation.
//   - An entry is popped for every writeback handshake.
//   - The whole queue is dropped on flush or reset.
// busy must equal "queue non-empty". Directed tasks check latency, stalls and boundaries.
module tb_mul_exec_stage;

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;

    mul_exec_if #(.TAG_W(5)) bus ();

    mul_exec_stage #(.TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int delivered = 0;

    logic [31:0] exp_res[$];
    logic [4:0]  exp_tag[$];
    logic [31:0] mon_r;
    logic [4:0]  mon_t;
    logic [31:0] mon_p;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard, evaluated at the falling edge when inputs and combinational outputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (busy !== (exp_res.size() != 0)) begin
                fails++;
                $display("FAIL busy_model: got %b want %b", busy, exp_res.size() != 0);
            end
            if (flush) begin
                tests++;
                if (bus.in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL flush_in_ready: got %b want 0", bus.in_ready);
                end
                exp_res.delete();
                exp_tag.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    tests++;
                    if (exp_res.size() == 0) begin
                        fails++;
                        $display("FAIL spurious_out: result %h tag %0d with nothing in flight",
                                 bus.out_result, bus.out_tag);
                    end else begin
                        mon_r = exp_res.pop_front();
                        mon_t = exp_tag.pop_front();
                        delivered++;
                        if (bus.out_result !== mon_r || bus.out_tag !== mon_t) begin
                            fails++;
                            $display("FAIL out_order: got %h/%0d want %h/%0d",
                                     bus.out_result, bus.out_tag, mon_r, mon_t);
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    mon_p = bus.in_is_mul ? (bus.in_a & 32'hFFFF) * (bus.in_b & 32'hFFFF) : 32'd0;
                    exp_res.push_back(mon_p);
                    exp_tag.push_back(bus.in_tag);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op and holds it until accepted. Returns the number of stalled cycles.
    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                           input logic [4:0] t, output int waited);
        bit done;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_is_mul = m;
        bus.in_tag    = t;
        bus.in_valid  = 1'b1;
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 50) begin
                    tests++;
                    fails++;
                    $display("FAIL send_timeout: in_ready stuck at 0 for tag %0d", t);
                    done = 1'b1;
                end
            end
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_is_mul = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_result !== 32'd0 ||
            bus.out_tag !== 5'd0) begin
            fails++;
            $display("FAIL reset_state: valid %b busy %b result %h tag %0d want all 0",
                     bus.out_valid, busy, bus.out_result, bus.out_tag);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_single();
        int w;
        bus.out_ready = 1'b1;
        send_op(32'h0000_1234, 32'h0000_5678, 1'b1, 5'd3, w);
        tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_s1: valid %b busy %b want 0 1", bus.out_valid, busy);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0626_0060 || bus.out_tag !== 5'd3) begin
            fails++;
            $display("FAIL single_out: valid %b result %h tag %0d want 1 06260060 3",
                     bus.out_valid, bus.out_result, bus.out_tag);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_drain: valid %b busy %b want 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic test_upper_bits();
        int w;
        send_op(32'hABCD_FFFF, 32'h1234_FFFF, 1'b1, 5'd17, w);
        tick();
        tests++;
        if (bus.out_result !== 32'hFFFE_0001 || bus.out_tag !== 5'd17) begin
            fails++;
            $display("FAIL max_operands: result %h tag %0d want fffe0001 17",
                     bus.out_result, bus.out_tag);
        end
        send_op(32'hABCD_FFFF, 32'h1234_FFFF, 1'b0, 5'd18, w);
        tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd0 || bus.out_tag !== 5'd18) begin
            fails++;
            $display("FAIL non_mul: valid %b result %h tag %0d want 1 0 18",
                     bus.out_valid, bus.out_result, bus.out_tag);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int w;
        int d0;
        d0 = delivered;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_op(i + 1, i + 2, 1'b1, 5'(i), w);
            tests++;
            if (w != 0) begin
                fails++;
                $display("FAIL stream_stall: op %0d waited %0d cycles want 0", i, w);
            end
        end
        // The last op appears one edge after acceptance.
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd56 || bus.out_tag !== 5'd6) begin
            fails++;
            $display("FAIL stream_tail: valid %b result %0d tag %0d want 1 56 6",
                     bus.out_valid, bus.out_result, bus.out_tag);
        end
        tick();
        tick();
        tick();
        tests++;
        if (delivered - d0 != 8) begin
            fails++;
            $display("FAIL stream_count: delivered %0d want 8", delivered - d0);
        end
    endtask

    task automatic test_backpressure();
        int w;
        int d0;
        d0 = delivered;
        bus.out_ready = 1'b0;
        send_op(32'd100, 32'd3, 1'b1, 5'd20, w);
        send_op(32'd200, 32'd3, 1'b1, 5'd21, w);
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_in_ready: got %b want 0 after two accepts", bus.in_ready);
        end
        bus.in_a      = 32'd300;
        bus.in_b      = 32'd3;
        bus.in_is_mul = 1'b1;
        bus.in_tag    = 5'd22;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'd300 ||
                bus.out_tag !== 5'd20) begin
                fails++;
                $display("FAIL bp_hold: ready %b valid %b result %0d tag %0d want 0 1 300 20",
                         bus.in_ready, bus.out_valid, bus.out_result, bus.out_tag);
            end
        end
        tick();
        bus.out_ready = 1'b1;
        send_op(32'd300, 32'd3, 1'b1, 5'd22, w);
        send_op(32'd400, 32'd3, 1'b1, 5'd23, w);
        tick();
        tick();
        tick();
        tests++;
        if (delivered - d0 != 4 || exp_res.size() != 0) begin
            fails++;
            $display("FAIL bp_count: delivered %0d pending %0d want 4 0",
                     delivered - d0, exp_res.size());
        end
    endtask

    task automatic test_flush();
        int w;
        bus.out_ready = 1'b0;
        send_op(32'd7, 32'd9, 1'b1, 5'd1, w);
        send_op(32'd8, 32'd9, 1'b1, 5'd2, w);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_ready_direct: got %b want 0", bus.in_ready);
        end
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_clear: valid %b busy %b want 0 0", bus.out_valid, busy);
        end
        bus.out_ready = 1'b1;
        send_op(32'd11, 32'd13, 1'b1, 5'd9, w);
        tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd143 || bus.out_tag !== 5'd9) begin
            fails++;
            $display("FAIL flush_after: valid %b result %0d tag %0d want 1 143 9",
                     bus.out_valid, bus.out_result, bus.out_tag);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int w;
        bus.out_ready = 1'b1;
        send_op(32'd5, 32'd6, 1'b1, 5'd4, w);
        send_op(32'd7, 32'd6, 1'b1, 5'd5, w);
        send_op(32'd9, 32'd6, 1'b1, 5'd6, w);
        #2;
        rst_n = 1'b0;
        #1;
        exp_res.delete();
        exp_tag.delete();
        tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_result !== 32'd0) begin
            fails++;
            $display("FAIL async_reset: valid %b busy %b result %h want 0 0 0",
                     bus.out_valid, busy, bus.out_result);
        end
        tick();
        #2;
        rst_n = 1'b1;
        send_op(32'h0000_0101, 32'h0000_0202, 1'b1, 5'd30, w);
        tick();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0002_0402 || bus.out_tag !== 5'd30) begin
            fails++;
            $display("FAIL reset_recover: valid %b result %h tag %0d want 1 00020402 30",
                     bus.out_valid, bus.out_result, bus.out_tag);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_a      = $urandom;
            bus.in_b      = $urandom;
            bus.in_is_mul = ($urandom_range(0, 7) != 0);
            bus.in_tag    = 5'($urandom_range(0, 31));
            bus.out_ready = 1'($urandom_range(0, 1));
            flush         = ($urandom_range(0, 24) == 0);
            tick();
        end
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        tests++;
        if (exp_res.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL random_drain: pending %0d busy %b want 0 0", exp_res.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_upper_bits();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_exec_stage.md
Name: mul_exec_stage

Overview:
Two-stage pipelined execute slot for multiply operations in the processor's execute unit. It accepts decoded operands and a destination tag from the issue logic over a valid/ready handshake. It registers them and drives the team's combinational 16x16 compressor-tree multiplier. It then holds the 32-bit product in an output register for the writeback stage, which consumes it over a second valid/ready handshake. The block owns all stall, backpressure and flush handling around the purely combinational multiplier.

Parameters:
TAG_W, 5, width of destination-register tag carried alongside each operation (32 architectural registers).

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  issue stage presents an operation
in_ready  output  1  block can accept an operation this cycle
in_a  input  32  operand A; only bits [15:0] are used arithmetically
in_b  input  32  operand B; only bits [15:0] are used arithmetically
in_is_mul  input  1  1 = multiply, 0 = non-multiply op (result forced 0)
in_tag  input  TAG_W  destination register tag
flush  input  1  synchronous pipeline kill (branch mispredict/exception)
out_valid  output  1  result register holds a valid result
out_ready  input  1  writeback accepts result this cycle
out_result  output  32  product
out_tag  output  TAG_W  tag of out_result
busy  output  1  any stage occupied

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, out_valid=0, out_result=0, out_tag=0, S1 operand/tag/is_mul registers=0. in_ready=1 and busy=0 once rst_n is high, unless flush is asserted.
- Stage S1 registers: a, b, is_mul, tag, s1_valid.
- Arithmetic, combinational from S1: prod = is_mul ? ({16'b0,a[15:0]} * {16'b0,b[15:0]}) : 0.
  - 32-bit, unsigned, no overflow possible.
  - A[31:16] and B[31:16] are ignored.
- s2_load = s1_valid & (~out_valid | out_ready).
- in_ready = ~flush & (~s1_valid | s2_load). in_ready depends combinationally on out_ready; this is an allowed path.
- Input accept: in_valid & in_ready at an edge → S1 captures in_a, in_b, in_is_mul, in_tag; s1_valid=1.
- S1 drain without refill: s2_load & ~accept → s1_valid=0.
- s2_load at an edge → out_result=prod, out_tag=S1 tag, out_valid=1.
- Output drain: out_valid & out_ready & ~s2_load → out_valid=0.
- Latency:
  - An op accepted at edge k appears on out_* (out_valid=1) after edge k+1, i.e. two cycles from the in handshake to the out handshake.
  - Throughput is 1 op/cycle with out_ready held high.
- Backpressure:
  - While out_valid & ~out_ready, out_result and out_tag hold stable.
  - S1 holds one further op; in_ready drops once S1 is occupied and the output is stalled.
  - No op is lost or duplicated.
- Simultaneous events:
  - Output drain, S1→S2 advance and new accept may all occur at one edge.
  - In-order delivery is guaranteed; ops never overtake.
- Flush:
  - flush=1 at an edge → s1_valid=0 and out_valid=0. out_result and out_tag keep their stale values, which are don't-care.
  - in_ready=0 during flush, so no accept happens in the flush cycle.
  - flush overrides any out handshake in that cycle; writeback must ignore out_valid when flush is high.
- Reset mid-operation clears both stages immediately; no result is emitted.
- busy = s1_valid | out_valid.
- Non-multiply ops (in_is_mul=0) flow through the pipeline normally with out_result=0, preserving order and tags.

Test Plan:
- Single op: after reset, in_a=0x0000_1234, in_b=0x0000_5678, is_mul=1, tag=3, out_ready=1 → two cycles later out_valid=1, out_result=0x0626_0060, out_tag=3; busy falls one cycle after the handshake.
- Upper bits ignored, max operands: in_a=0xABCD_FFFF, in_b=0x1234_FFFF → out_result=0xFFFE_0001; is_mul=0 with the same operands → out_result=0.
- Streaming: 8 back-to-back ops (a=i+1, b=i+2, tags 0..7), out_ready=1 → in_ready stays 1; results 2,6,12,...,72 in order on consecutive cycles.
- Backpressure: stream 4 ops with out_ready=0 → in_ready drops after 2 ops accepted; out_result holds op0; releasing out_ready delivers op0..op3 in order, none lost.
- Flush: two ops in flight (S1 and output), flush pulsed for one cycle → out_valid=0 and busy=0 next cycle, in_ready=0 during flush; a following op completes normally with its correct tag.
- Async reset: assert rst_n=0 mid-stream between clock edges → out_valid, busy and out_result go to 0 immediately; after release, the first new op returns a correct result.
